// File: rtl/cpu_trace_pkg.sv
// Shared types for the cpu trace monitor: FSM states, record flag bit positions
// and the trace record layout at the default widths (16-bit data/address, 4-bit index).
package cpu_trace_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    DRAIN   = 3'd2,
    DONE    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  localparam int FLG_REG = 2;
  localparam int FLG_LD  = 1;
  localparam int FLG_ST  = 0;

  typedef struct packed {
    logic [2:0]  flags;
    logic [3:0]  reg_idx;
    logic [15:0] reg_data;
    logic [15:0] addr;
    logic [15:0] mdata;
  } trc_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Show-ahead FIFO for trace records; a pop in the same cycle frees room for a push
// into a full FIFO. Full/empty come from an extra wrap bit on each pointer.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_pop_ok;
  logic             w_push_ok;

  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);
  assign head      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset: contents are only observable once the pointers say so.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// Snoops MEM/WB commits, keeps cycle/inst/stall/drop counters and a watchdog,
// and buffers one record per committing cycle. Macro TRACE_CYCLE_STAMP_EN adds trc_stamp.
module cpu_trace_monitor
  import cpu_trace_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int REG_IDX_W  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 100000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 reg_we,
  input  logic [REG_IDX_W-1:0] reg_idx,
  input  logic [DATA_W-1:0]    reg_data,
  input  logic                 mem_rd,
  input  logic                 mem_wr,
  input  logic                 mem_notdone,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [DATA_W-1:0]    mem_wdata,
  input  logic [DATA_W-1:0]    mem_rdata,
  input  logic                 hlt,
  output logic                 trc_valid,
  input  logic                 trc_ready,
  output logic [2:0]           trc_flags,
  output logic [REG_IDX_W-1:0] trc_reg,
  output logic [DATA_W-1:0]    trc_rdata,
  output logic [ADDR_W-1:0]    trc_addr,
  output logic [DATA_W-1:0]    trc_mdata,
`ifdef TRACE_CYCLE_STAMP_EN
  output logic [CNT_W-1:0]     trc_stamp,
`endif
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     inst_cnt,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 done,
  output logic                 timeout
);

  typedef struct packed {
    logic [2:0]           flags;
    logic [REG_IDX_W-1:0] reg_idx;
    logic [DATA_W-1:0]    reg_data;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    mdata;
`ifdef TRACE_CYCLE_STAMP_EN
    logic [CNT_W-1:0]     stamp;
`endif
  } rec_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_inst_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             w_ld;
  logic             w_st;
  logic             w_event;
  logic             w_run;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [2:0]       w_flags;
  rec_t             w_rec;
  rec_t             w_head;

  assign w_ld    = mem_rd & ~mem_notdone;
  assign w_st    = mem_wr & ~mem_notdone;
  assign w_event = reg_we | w_ld | w_st;
  assign w_run   = (r_state == RUN);
  assign w_push  = w_run & w_event;
  assign w_pop   = trc_valid & trc_ready;

  always_comb begin
    w_flags          = '0;
    w_flags[FLG_REG] = reg_we;
    w_flags[FLG_LD]  = w_ld;
    w_flags[FLG_ST]  = w_st;
  end

  always_comb begin
    w_rec          = '0;
    w_rec.flags    = w_flags;
    w_rec.reg_idx  = reg_idx;
    w_rec.reg_data = reg_data;
    w_rec.addr     = mem_addr;
    w_rec.mdata    = w_st ? mem_wdata : mem_rdata;
`ifdef TRACE_CYCLE_STAMP_EN
    w_rec.stamp    = r_cycle_cnt;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Halt wins over the watchdog when both land on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = RUN;
      RUN: begin
        if (hlt)                                         w_state_nxt = DRAIN;
        else if (r_cycle_cnt == CNT_W'(WDOG_LIMIT - 1)) w_state_nxt = TIMEOUT;
      end
      DRAIN:   if (w_empty) w_state_nxt = DONE;
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else if (w_run) begin
      r_cycle_cnt <= sat_inc(r_cycle_cnt);
      if (mem_notdone)                r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_event | hlt)              r_inst_cnt  <= sat_inc(r_inst_cnt);
      if (w_push & w_full & ~w_pop)   r_drop_cnt  <= sat_inc(r_drop_cnt);
    end
  end

  trace_fifo #(
    .WIDTH ($bits(rec_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_rec),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  assign trc_valid = ~w_empty;
  assign trc_flags = w_head.flags;
  assign trc_reg   = w_head.reg_idx;
  assign trc_rdata = w_head.reg_data;
  assign trc_addr  = w_head.addr;
  assign trc_mdata = w_head.mdata;
`ifdef TRACE_CYCLE_STAMP_EN
  assign trc_stamp = w_head.stamp;
`endif
  assign cycle_cnt = r_cycle_cnt;
  assign inst_cnt  = r_inst_cnt;
  assign stall_cnt = r_stall_cnt;
  assign drop_cnt  = r_drop_cnt;
  assign done      = (r_state == DONE);
  assign timeout   = (r_state == TIMEOUT);

endmodule

// File: tb/tb_cpu_trace_monitor.sv
// Directed bench for cpu_trace_monitor: one default-watchdog instance and one with
// WDOG_LIMIT=20, both driven by the same stimulus.
module tb_cpu_trace_monitor;

  logic        clk;
  logic        rst_n;
  logic        reg_we;
  logic [3:0]  reg_idx;
  logic [15:0] reg_data;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_notdone;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        hlt;
  logic        trc_ready;

  logic        trc_valid;
  logic [2:0]  trc_flags;
  logic [3:0]  trc_reg;
  logic [15:0] trc_rdata, trc_addr, trc_mdata;
  logic [31:0] cycle_cnt, inst_cnt, stall_cnt, drop_cnt;
  logic        done, timeout;

  logic        wd_trc_valid;
  logic [2:0]  wd_trc_flags;
  logic [3:0]  wd_trc_reg;
  logic [15:0] wd_trc_rdata, wd_trc_addr, wd_trc_mdata;
  logic [31:0] wd_cycle_cnt, wd_inst_cnt, wd_stall_cnt, wd_drop_cnt;
  logic        wd_done, wd_timeout;
`ifdef TRACE_CYCLE_STAMP_EN
  logic [31:0] trc_stamp, wd_trc_stamp;
`endif

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [2:0]  q_flags[$];
  logic [3:0]  q_reg[$];
  logic [15:0] q_rdata[$];
  logic [15:0] q_addr[$];
  logic [15:0] q_mdata[$];

  cpu_trace_monitor dut (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_notdone(mem_notdone), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
    .trc_valid(trc_valid), .trc_ready(trc_ready), .trc_flags(trc_flags), .trc_reg(trc_reg),
    .trc_rdata(trc_rdata), .trc_addr(trc_addr), .trc_mdata(trc_mdata),
`ifdef TRACE_CYCLE_STAMP_EN
    .trc_stamp(trc_stamp),
`endif
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt), .stall_cnt(stall_cnt), .drop_cnt(drop_cnt),
    .done(done), .timeout(timeout)
  );

  cpu_trace_monitor #(.WDOG_LIMIT(20)) dut_wd (
    .clk(clk), .rst_n(rst_n), .reg_we(reg_we), .reg_idx(reg_idx), .reg_data(reg_data),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_notdone(mem_notdone), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .hlt(hlt),
    .trc_valid(wd_trc_valid), .trc_ready(trc_ready), .trc_flags(wd_trc_flags),
    .trc_reg(wd_trc_reg), .trc_rdata(wd_trc_rdata), .trc_addr(wd_trc_addr),
    .trc_mdata(wd_trc_mdata),
`ifdef TRACE_CYCLE_STAMP_EN
    .trc_stamp(wd_trc_stamp),
`endif
    .cycle_cnt(wd_cycle_cnt), .inst_cnt(wd_inst_cnt), .stall_cnt(wd_stall_cnt),
    .drop_cnt(wd_drop_cnt), .done(wd_done), .timeout(wd_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records accepted by the consumer; sampled mid-cycle, popped on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && trc_valid && trc_ready) begin
      q_flags.push_back(trc_flags);
      q_reg.push_back(trc_reg);
      q_rdata.push_back(trc_rdata);
      q_addr.push_back(trc_addr);
      q_mdata.push_back(trc_mdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    reg_we = 0; reg_idx = 0; reg_data = 0; mem_rd = 0; mem_wr = 0; mem_notdone = 0;
    mem_addr = 0; mem_wdata = 0; mem_rdata = 0; hlt = 0; trc_ready = 0;
  endtask

  // Leaves both monitors just after the IDLE->RUN edge.
  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
    tick();
    q_flags.delete(); q_reg.delete(); q_rdata.delete(); q_addr.delete(); q_mdata.delete();
  endtask

  initial begin
    logic [15:0] exp_i;
    clear_inputs();
    rst_n = 0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", trc_valid, 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_inst", inst_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);

    // register writes streaming straight through
    do_reset();
    trc_ready = 1; reg_we = 1; reg_idx = 4'd3; reg_data = 16'h00AA;
    repeat (5) tick();
    reg_we = 0;
    chk("t1_cycle", cycle_cnt, 5);
    chk("t1_inst", inst_cnt, 5);
    tick();
    chk("t1_nrec", q_flags.size(), 5);
    for (int i = 0; i < q_flags.size(); i++) begin
      chk("t1_flags", q_flags[i], 3'b100);
      chk("t1_reg", q_reg[i], 4'd3);
      chk("t1_rdata", q_rdata[i], 16'h00AA);
    end

    // load held off by mem_notdone
    do_reset();
    trc_ready = 1; mem_rd = 1; mem_notdone = 1; mem_addr = 16'h0040; mem_rdata = 16'h1234;
    repeat (3) tick();
    chk("t2_nostall_rec", trc_valid, 0);
    mem_notdone = 0;
    tick();
    mem_rd = 0;
    chk("t2_stall", stall_cnt, 3);
    chk("t2_inst", inst_cnt, 1);
    chk("t2_cycle", cycle_cnt, 4);
    tick();
    chk("t2_nrec", q_flags.size(), 1);
    if (q_flags.size() > 0) begin
      chk("t2_flags", q_flags[0], 3'b010);
      chk("t2_addr", q_addr[0], 16'h0040);
      chk("t2_mdata", q_mdata[0], 16'h1234);
    end

    // overflow: 10 stores into 8 slots, then push into a full FIFO while popping
    do_reset();
    trc_ready = 0; mem_wr = 1;
    for (int i = 0; i < 10; i++) begin
      mem_addr = 16'h0200 + 16'(i); mem_wdata = 16'h0100 + 16'(i);
      tick();
    end
    chk("t3_drop", drop_cnt, 2);
    chk("t3_inst", inst_cnt, 10);
    chk("t3_valid", trc_valid, 1);
    trc_ready = 1; mem_addr = 16'h020A; mem_wdata = 16'h010A;
    tick();
    mem_wr = 0;
    repeat (10) tick();
    chk("t3_drop_after", drop_cnt, 2);
    chk("t3_nrec", q_flags.size(), 9);
    for (int i = 0; i < q_flags.size(); i++) begin
      exp_i = (i < 8) ? 16'(i) : 16'd10;
      chk("t3_flags", q_flags[i], 3'b001);
      chk("t3_addr", q_addr[i], 16'h0200 + exp_i);
      chk("t3_mdata", q_mdata[i], 16'h0100 + exp_i);
    end

    // halt with 3 records pending, then drain
    do_reset();
    trc_ready = 0; reg_we = 1; reg_idx = 4'd5; reg_data = 16'h0055;
    repeat (2) tick();
    hlt = 1;
    tick();
    reg_we = 0; hlt = 0;
    repeat (3) tick();
    chk("t4_cycle_frozen", cycle_cnt, 3);
    chk("t4_inst_frozen", inst_cnt, 3);
    chk("t4_done_early", done, 0);
    chk("t4_valid", trc_valid, 1);
    trc_ready = 1;
    repeat (3) tick();
    chk("t4_empty", trc_valid, 0);
    chk("t4_done_pending", done, 0);
    tick();
    chk("t4_done", done, 1);
    chk("t4_timeout", timeout, 0);
    chk("t4_nrec", q_flags.size(), 3);

    // watchdog on the WDOG_LIMIT=20 instance
    do_reset();
    repeat (19) tick();
    chk("t5_cycle19", wd_cycle_cnt, 19);
    chk("t5_not_yet", wd_timeout, 0);
    tick();
    chk("t5_timeout", wd_timeout, 1);
    chk("t5_cycle20", wd_cycle_cnt, 20);
    repeat (3) tick();
    chk("t5_cycle_hold", wd_cycle_cnt, 20);
    chk("t5_done", wd_done, 0);
    chk("t5_main_no_timeout", timeout, 0);

    // asynchronous reset with a half-full FIFO
    do_reset();
    reg_we = 1; reg_idx = 4'd7; reg_data = 16'h0777;
    repeat (4) tick();
    reg_we = 0;
    chk("t6_valid_pre", trc_valid, 1);
    chk("t6_inst_pre", inst_cnt, 4);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("t6_valid", trc_valid, 0);
    chk("t6_cycle", cycle_cnt, 0);
    chk("t6_inst", inst_cnt, 0);
    chk("t6_done", done, 0);
    chk("t6_timeout", timeout, 0);
    tick();
    rst_n = 1;
    tick();
    tick();
    chk("t6_still_empty", trc_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
